// File: rtl/data_memory_if.sv
// Line-request bus between the data cache controller (master) and main data memory (slave).
// Optional DMEM_OOR_ERR_EN adds the err_o out-of-range flag.
interface data_memory_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
`ifdef DMEM_OOR_ERR_EN
    logic              err_o;
`endif

    modport master (
        output addr_i,
        output data_i,
        output enable_i,
        output write_i,
        input  ack_o,
        input  data_o
`ifdef DMEM_OOR_ERR_EN
        , input err_o
`endif
    );

    modport slave (
        input  addr_i,
        input  data_i,
        input  enable_i,
        input  write_i,
        output ack_o,
        output data_o
`ifdef DMEM_OOR_ERR_EN
        , output err_o
`endif
    );
endinterface

// File: rtl/data_memory.sv
// Main data memory model: whole-line reads/writes with fixed latency and a one-cycle ack.
// Define DMEM_OOR_ERR_EN to reject (and flag via err_o) accesses with upper address bits set.
module data_memory #(
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    data_memory_if.slave bus
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    logic [LINE_W-1:0] memory [0:DEPTH-1];

    state_t            state_r,   state_s;
    logic [7:0]        counter_r, counter_s;
    logic [IDX_W-1:0]  index_r,   index_s;
    logic [LINE_W-1:0] wdata_r,   wdata_s;
    logic              write_r,   write_s;
    logic              ack_r,     ack_s;
    logic [LINE_W-1:0] data_r,    data_s;
    logic              mem_we_s;
`ifdef DMEM_OOR_ERR_EN
    logic              oor_r,     oor_s;
    logic              err_r,     err_s;
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_s   = state_r;
        counter_s = counter_r;
        index_s   = index_r;
        wdata_s   = wdata_r;
        write_s   = write_r;
        ack_s     = 1'b0;
        data_s    = data_r;
        mem_we_s  = 1'b0;
`ifdef DMEM_OOR_ERR_EN
        oor_s     = oor_r;
        err_s     = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.enable_i) begin
                    index_s   = bus.addr_i[IDX_W+OFF_W-1:OFF_W];
                    wdata_s   = bus.data_i;
                    write_s   = bus.write_i;
`ifdef DMEM_OOR_ERR_EN
                    oor_s     = |bus.addr_i[ADDR_W-1:IDX_W+OFF_W];
`endif
                    counter_s = 8'd1;
                    state_s   = ST_WAIT;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (counter_r == LAT_M1) begin
                    ack_s   = 1'b1;
                    state_s = ST_ACK;
`ifdef DMEM_OOR_ERR_EN
                    if (oor_r) begin
                        err_s  = 1'b1;
                        data_s = '0;
                    end else
`endif
                    if (write_r) begin
                        // Write ack echoes the written line so data_o always shows the accessed line
                        mem_we_s = 1'b1;
                        data_s   = wdata_r;
                    end else begin
                        data_s   = memory[index_r];
                    end
                end else begin
                    counter_s = counter_r + 8'd1;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_IDLE;
            counter_r <= 8'd0;
            index_r   <= '0;
            wdata_r   <= '0;
            write_r   <= 1'b0;
            ack_r     <= 1'b0;
            data_r    <= '0;
`ifdef DMEM_OOR_ERR_EN
            oor_r     <= 1'b0;
            err_r     <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            counter_r <= counter_s;
            index_r   <= index_s;
            wdata_r   <= wdata_s;
            write_r   <= write_s;
            ack_r     <= ack_s;
            data_r    <= data_s;
`ifdef DMEM_OOR_ERR_EN
            oor_r     <= oor_s;
            err_r     <= err_s;
`endif
        end
    end

    // Line storage; contents survive reset, and a reset edge blocks a pending write
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we_s) begin
            memory[index_r] <= wdata_r;
        end
    end

    assign bus.ack_o  = ack_r;
    assign bus.data_o = data_r;
`ifdef DMEM_OOR_ERR_EN
    assign bus.err_o  = err_r;
`endif
endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory (default build and DMEM_OOR_ERR_EN build).
module tb_data_memory;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   total = 0;
    int   bad   = 0;

    data_memory_if #(.LINE_W(256), .ADDR_W(32)) bus ();

    data_memory #(.LINE_W(256), .DEPTH(512), .ADDR_W(32), .LATENCY(10)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic get_err();
`ifdef DMEM_OOR_ERR_EN
        return bus.err_o;
`else
        return 1'b0;
`endif
    endfunction

    // Issue one request from idle; edges counts edges from acceptance (edge 1) to ack seen, -1 on timeout.
    task automatic req(input logic [31:0] a, input logic [255:0] d, input logic w, input bit scramble,
                       output int edges, output logic [255:0] rd, output logic er);
        bus.addr_i = a; bus.data_i = d; bus.write_i = w; bus.enable_i = 1'b1;
        tick();
        edges = 1;
        if (scramble) begin
            bus.addr_i = a ^ 32'h0000_0040; bus.data_i = ~d; bus.write_i = ~w;
        end
        rd = '0; er = 1'b0;
        while (bus.ack_o !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        if (bus.ack_o !== 1'b1) edges = -1;
        else begin rd = bus.data_o; er = get_err(); end
        bus.enable_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; bus.enable_i = 1'b0; bus.write_i = 1'b0;
        bus.addr_i = 32'h0; bus.data_i = '0;
        tick(); tick();
        total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.ack_o); end
        total++; if (bus.data_o !== 256'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.data_o); end
`ifdef DMEM_OOR_ERR_EN
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err_o); end
`endif
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_read_latency();
        int e; logic [255:0] rd; logic er;
        dut.memory[0] = 256'h5;
        req(32'h0000_0000, 256'h0, 1'b0, 1'b0, e, rd, er);
        total++; if (e != 10) begin bad++; $display("FAIL read_latency got=%0d want=10", e); end
        total++; if (rd !== 256'h5) begin bad++; $display("FAIL read_data got=%h want=5", rd); end
        total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL read_pulse got=%b want=0", bus.ack_o); end
        total++; if (bus.data_o !== 256'h5) begin bad++; $display("FAIL read_hold got=%h want=5", bus.data_o); end
    endtask

    task automatic test_write_read();
        int e; logic [255:0] rd; logic er; bit early; bit seen;
        logic [255:0] wline;
        wline = {8{32'hDEADBEEF}};
        dut.memory[1] = 256'h11;
        early = 1'b0; seen = 1'b0;
        bus.addr_i = 32'h0000_0020; bus.data_i = wline; bus.write_i = 1'b1; bus.enable_i = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            tick();
            if (bus.ack_o === 1'b1) seen = 1'b1;
            else if (dut.memory[1] !== 256'h11) early = 1'b1;
        end
        total++; if (early) begin bad++; $display("FAIL write_early got=%h want=11", dut.memory[1]); end
        total++; if (dut.memory[1] !== wline) begin bad++; $display("FAIL write_mem got=%h want=%h", dut.memory[1], wline); end
        total++; if (bus.data_o !== wline) begin bad++; $display("FAIL write_echo got=%h want=%h", bus.data_o, wline); end
        bus.enable_i = 1'b0;
        tick();
        req(32'h0000_0020, 256'h0, 1'b0, 1'b0, e, rd, er);
        total++; if (e != 10 || rd !== wline) begin bad++; $display("FAIL write_readback got=%0d/%h want=10/%h", e, rd, wline); end
    endtask

    task automatic test_back_to_back();
        int acks[$]; int prev;
        dut.memory[0] = 256'h5;
        bus.addr_i = 32'h0; bus.write_i = 1'b0; bus.enable_i = 1'b1;
        prev = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.ack_o === 1'b1) acks.push_back(k);
        end
        total++;
        if (acks.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", acks.size()); end
        else if (acks[0] != 10 || acks[1] != 21 || acks[2] != 32) begin
            bad++; $display("FAIL b2b_spacing got=%0d,%0d,%0d want=10,21,32", acks[0], acks[1], acks[2]);
        end
        bus.enable_i = 1'b0;
        for (int k = 0; k < 20 && bus.ack_o !== 1'b1; k++) tick();
        tick();
    endtask

    task automatic test_reset_abort();
        int e; logic [255:0] rd; logic er; bit spurious;
        dut.memory[32] = 256'hABCD;
        bus.addr_i = 32'h0000_0400; bus.data_i = 256'h9999; bus.write_i = 1'b1; bus.enable_i = 1'b1;
        tick(); tick(); tick(); tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; bus.enable_i = 1'b0;
        spurious = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.ack_o !== 1'b0) spurious = 1'b1;
        end
        total++; if (spurious) begin bad++; $display("FAIL abort_ack got=1 want=0"); end
        total++; if (dut.memory[32] !== 256'hABCD) begin bad++; $display("FAIL abort_mem got=%h want=abcd", dut.memory[32]); end
        req(32'h0000_0400, 256'h0, 1'b0, 1'b0, e, rd, er);
        total++; if (e != 10 || rd !== 256'hABCD) begin bad++; $display("FAIL abort_next got=%0d/%h want=10/abcd", e, rd); end
    endtask

    task automatic test_latch();
        int e; logic [255:0] rd; logic er;
        dut.memory[0] = 256'h5; dut.memory[2] = 256'h77;
        req(32'h0000_0000, 256'h1234, 1'b0, 1'b1, e, rd, er);
        total++; if (rd !== 256'h5) begin bad++; $display("FAIL latch_data got=%h want=5", rd); end
        total++; if (dut.memory[2] !== 256'h77) begin bad++; $display("FAIL latch_mem2 got=%h want=77", dut.memory[2]); end
        total++; if (e != 10) begin bad++; $display("FAIL latch_latency got=%0d want=10", e); end
    endtask

    task automatic test_oor();
        int e; logic [255:0] rd; logic er;
        dut.memory[0] = 256'h5;
        req(32'h0004_0000, 256'h0, 1'b0, 1'b0, e, rd, er);
        total++; if (e != 10) begin bad++; $display("FAIL oor_latency got=%0d want=10", e); end
`ifdef DMEM_OOR_ERR_EN
        total++; if (rd !== 256'h0 || er !== 1'b1) begin bad++; $display("FAIL oor_err got=%h/%b want=0/1", rd, er); end
        total++; if (bus.err_o !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got=%b want=0", bus.err_o); end
        req(32'h0004_0000, 256'hBAD, 1'b1, 1'b0, e, rd, er);
        total++; if (dut.memory[0] !== 256'h5 || er !== 1'b1) begin bad++; $display("FAIL oor_nowrite got=%h/%b want=5/1", dut.memory[0], er); end
`else
        total++; if (rd !== 256'h5) begin bad++; $display("FAIL oor_wrap got=%h want=5", rd); end
`endif
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_read();
        test_back_to_back();
        test_reset_abort();
        test_latch();
        test_oor();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
